// File: rtl/kadai4_mac_if.sv
// rtl/kadai4_mac_if.sv - host-side handshake bundle for the kadai4_mac dot-product engine
interface kadai4_mac_if;
  logic        START;
  logic        HALT;
  logic [7:0]  A;
  logic [7:0]  B;
  logic        ACK;
  logic        REQ_AB;
  logic [15:0] X;
  logic        X_VALID;

  modport master (
    output START, HALT, A, B, ACK,
    input  REQ_AB, X, X_VALID
  );

  modport slave (
    input  START, HALT, A, B, ACK,
    output REQ_AB, X, X_VALID
  );
endinterface

// File: rtl/kadai4_mac.sv
// rtl/kadai4_mac.sv - eight-pair unsigned dot-product engine with request/acknowledge operand loading
module kadai4_mac (
  input logic         CLK,
  input logic         RST,
  kadai4_mac_if.slave bus
);

  typedef enum logic [1:0] {IDLE, S_INPUT, S_EXEC, S_OUTPUT} state_t;

  state_t      state;
  logic [2:0]  cnt;
  logic [7:0]  a_mem [8];
  logic [7:0]  b_mem [8];
  logic [15:0] acc;
  logic [15:0] prod;
  logic        req_ab;
  logic        x_valid;

  // cnt doubles as capture slot index and execution step index
  always_comb begin
    prod = {8'h00, a_mem[cnt]} * {8'h00, b_mem[cnt]};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      cnt     <= 3'd0;
      acc     <= 16'h0000;
      req_ab  <= 1'b0;
      x_valid <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        a_mem[i] <= 8'h00;
        b_mem[i] <= 8'h00;
      end
    end else if (bus.HALT) begin
      state   <= IDLE;
      cnt     <= 3'd0;
      acc     <= 16'h0000;
      req_ab  <= 1'b0;
      x_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.START) begin
            state  <= S_INPUT;
            cnt    <= 3'd0;
            acc    <= 16'h0000;
            req_ab <= 1'b1;
          end
        end
        S_INPUT: begin
          if (req_ab && bus.ACK) begin
            a_mem[cnt] <= bus.A;
            b_mem[cnt] <= bus.B;
            if (cnt == 3'd7) begin
              state  <= S_EXEC;
              cnt    <= 3'd0;
              req_ab <= 1'b0;
            end else begin
              cnt <= cnt + 3'd1;
            end
          end
        end
        S_EXEC: begin
          acc <= acc + prod;
          if (cnt == 3'd7) begin
            state   <= S_OUTPUT;
            cnt     <= 3'd0;
            x_valid <= 1'b1;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        S_OUTPUT: begin
          // acc is left untouched so X holds the result after the consumer acks
          if (bus.ACK) begin
            state   <= IDLE;
            x_valid <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.REQ_AB  = req_ab;
  assign bus.X       = acc;
  assign bus.X_VALID = x_valid;

endmodule

// File: tb/tb_kadai4_mac.sv
// tb/tb_kadai4_mac.sv - directed self-checking bench for kadai4_mac
module tb_kadai4_mac;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  logic [7:0] op_a [8];
  logic [7:0] op_b [8];

  kadai4_mac_if bus();

  kadai4_mac dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input logic [7:0] a_val, input int b_base, input logic [7:0] b_fixed, input bit b_ramp);
    for (int i = 0; i < 8; i++) begin
      op_a[i] = a_val;
      op_b[i] = b_ramp ? 8'(b_base + i) : b_fixed;
    end
  endtask

  task automatic start_job();
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
    checks++;
    if (bus.REQ_AB !== 1'b1) begin
      errors++;
      $display("FAIL start_req_ab: got %b want 1", bus.REQ_AB);
    end
  endtask

  // mode 0: ACK every cycle, mode 1: ACK toggling, mode 2: START pulse mid-load
  task automatic load_pairs(input int mode);
    int   idx;
    int   budget;
    logic acked;
    idx = 0;
    budget = 0;
    while (idx < 8 && budget < 40) begin
      acked = (mode != 1) || (budget % 2 == 0);
      if (mode == 2 && budget == 3) begin
        bus.START = 1'b1;
        acked = 1'b0;
      end
      bus.ACK = acked;
      bus.A   = acked ? op_a[idx] : 8'hFF;
      bus.B   = acked ? op_b[idx] : 8'hFF;
      step();
      bus.START = 1'b0;
      if (acked) idx++;
      budget++;
    end
    bus.ACK = 1'b0;
    bus.A   = 8'h00;
    bus.B   = 8'h00;
    checks++;
    if (bus.REQ_AB !== 1'b0 || idx != 8) begin
      errors++;
      $display("FAIL req_ab_after_load: got req_ab=%b captured=%0d want req_ab=0 captured=8", bus.REQ_AB, idx);
    end
  endtask

  task automatic wait_valid(input logic [15:0] exp_x, input string name);
    int n;
    n = 0;
    while (bus.X_VALID !== 1'b1 && n < 12) begin
      step();
      n++;
    end
    checks++;
    if (bus.X_VALID !== 1'b1) begin
      errors++;
      $display("FAIL %s_valid_timeout: x_valid=%b after %0d cycles want 1", name, bus.X_VALID, n);
    end
    checks++;
    if (bus.X !== exp_x) begin
      errors++;
      $display("FAIL %s_result: got X=%0d want %0d", name, bus.X, exp_x);
    end
  endtask

  task automatic ack_result(input logic [15:0] exp_x, input string name);
    bus.ACK = 1'b1;
    step();
    bus.ACK = 1'b0;
    checks++;
    if (bus.X_VALID !== 1'b0 || bus.X !== exp_x || bus.REQ_AB !== 1'b0) begin
      errors++;
      $display("FAIL %s_ack: got x_valid=%b X=%0d req_ab=%b want 0 %0d 0", name, bus.X_VALID, bus.X, bus.REQ_AB, exp_x);
    end
  endtask

  task automatic check_cleared(input string name);
    checks++;
    if (bus.REQ_AB !== 1'b0 || bus.X !== 16'h0000 || bus.X_VALID !== 1'b0) begin
      errors++;
      $display("FAIL %s_cleared: got req_ab=%b X=%0d x_valid=%b want 0 0 0", name, bus.REQ_AB, bus.X, bus.X_VALID);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.START = 1'b0;
    bus.HALT  = 1'b0;
    bus.ACK   = 1'b0;
    bus.A     = 8'h00;
    bus.B     = 8'h00;
    repeat (10) step();
    rst = 1'b0;
    check_cleared("reset");
    bus.ACK = 1'b1;
    step();
    bus.ACK = 1'b0;
    check_cleared("ack_in_idle");
  endtask

  task automatic test_basic();
    set_ops(8'd1, 1, 8'd0, 1'b1);
    start_job();
    load_pairs(0);
    wait_valid(16'd36, "basic");
    repeat (2) step();
    checks++;
    if (bus.X_VALID !== 1'b1 || bus.X !== 16'd36) begin
      errors++;
      $display("FAIL basic_hold: got x_valid=%b X=%0d want 1 36", bus.X_VALID, bus.X);
    end
    ack_result(16'd36, "basic");
  endtask

  task automatic test_wrap();
    set_ops(8'd255, 0, 8'd255, 1'b0);
    start_job();
    load_pairs(0);
    wait_valid(16'hF008, "wrap");
    ack_result(16'hF008, "wrap");
  endtask

  task automatic test_ack_gaps();
    set_ops(8'd2, 1, 8'd0, 1'b1);
    start_job();
    load_pairs(1);
    wait_valid(16'd72, "gaps");
    ack_result(16'd72, "gaps");
  endtask

  task automatic test_halt_input();
    set_ops(8'd1, 1, 8'd0, 1'b1);
    start_job();
    bus.ACK = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bus.A = op_a[i];
      bus.B = op_b[i];
      step();
    end
    bus.ACK  = 1'b0;
    bus.HALT = 1'b1;
    step();
    bus.HALT = 1'b0;
    check_cleared("halt_input");
    set_ops(8'd1, 1, 8'd0, 1'b1);
    start_job();
    load_pairs(0);
    wait_valid(16'd36, "restart");
    ack_result(16'd36, "restart");
  endtask

  task automatic test_halt_exec();
    set_ops(8'd1, 1, 8'd0, 1'b1);
    start_job();
    load_pairs(0);
    repeat (3) step();
    checks++;
    if (bus.X !== 16'd6 || bus.X_VALID !== 1'b0) begin
      errors++;
      $display("FAIL exec_partial: got X=%0d x_valid=%b want 6 0", bus.X, bus.X_VALID);
    end
    bus.HALT = 1'b1;
    step();
    bus.HALT = 1'b0;
    check_cleared("halt_exec");
    repeat (10) step();
    check_cleared("halt_exec_stays");
  endtask

  task automatic test_halt_output();
    set_ops(8'd1, 1, 8'd0, 1'b1);
    start_job();
    load_pairs(0);
    wait_valid(16'd36, "out_hold");
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (bus.X_VALID !== 1'b1 || bus.X !== 16'd36) begin
        errors++;
        $display("FAIL out_hold_%0d: got x_valid=%b X=%0d want 1 36", i, bus.X_VALID, bus.X);
      end
    end
    bus.HALT = 1'b1;
    step();
    bus.HALT = 1'b0;
    check_cleared("halt_output");
  endtask

  task automatic test_start_ignored();
    set_ops(8'd3, 1, 8'd0, 1'b1);
    start_job();
    load_pairs(2);
    wait_valid(16'd108, "start_in_input");
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
    checks++;
    if (bus.X_VALID !== 1'b1 || bus.REQ_AB !== 1'b0 || bus.X !== 16'd108) begin
      errors++;
      $display("FAIL start_in_output: got x_valid=%b req_ab=%b X=%0d want 1 0 108", bus.X_VALID, bus.REQ_AB, bus.X);
    end
    ack_result(16'd108, "start_ignored");
  endtask

  task automatic test_halt_start_idle();
    bus.HALT  = 1'b1;
    bus.START = 1'b1;
    step();
    bus.HALT  = 1'b0;
    bus.START = 1'b0;
    check_cleared("halt_start_idle");
    step();
    check_cleared("halt_start_idle_next");
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_wrap();
    test_ack_gaps();
    test_halt_input();
    test_halt_exec();
    test_halt_output();
    test_start_ignored();
    test_halt_start_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
